// File: rtl/rr_lock_arbiter_if.sv
// rtl/rr_lock_arbiter_if.sv - request/grant bundle between port request logic and the arbiter
interface rr_lock_arbiter_if #(
  parameter int P_CHANNEL_NUM = 8,
  parameter int P_IDX_WIDTH   = 3
);
  logic [P_CHANNEL_NUM-1:0] i_req;
  logic                     i_req_valid;
  logic                     i_release;
  logic [P_CHANNEL_NUM-1:0] o_grant;
  logic [P_IDX_WIDTH-1:0]   o_grant_idx;
  logic                     o_grant_valid;
  logic                     o_busy;
  logic                     o_timeout;

  modport master (
    output i_req, i_req_valid, i_release,
    input  o_grant, o_grant_idx, o_grant_valid, o_busy, o_timeout
  );

  modport slave (
    input  i_req, i_req_valid, i_release,
    output o_grant, o_grant_idx, o_grant_valid, o_busy, o_timeout
  );
endinterface

// File: rtl/rr_lock_arbiter.sv
// rtl/rr_lock_arbiter.sv - round-robin arbiter with grant locking and post-release dead cycle
// Optional forced release after P_MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_lock_arbiter #(
  parameter int P_CHANNEL_NUM = 8,
  parameter int P_IDX_WIDTH   = 3,
  parameter int P_MAX_HOLD    = 256
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  rr_lock_arbiter_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} state_t;

  localparam logic [P_IDX_WIDTH-1:0] LAST_IDX = P_IDX_WIDTH'(P_CHANNEL_NUM - 1);

  if (P_CHANNEL_NUM < 2 || P_IDX_WIDTH < $clog2(P_CHANNEL_NUM) || P_MAX_HOLD < 2) begin : g_param_check
    $error("rr_lock_arbiter: illegal parameter combination");
  end

  state_t                   state, state_n;
  logic [P_IDX_WIDTH-1:0]   ptr, ptr_n;
  logic [P_CHANNEL_NUM-1:0] grant_n;
  logic [P_IDX_WIDTH-1:0]   idx_n;
  logic                     gv_n, busy_n, to_n;
  logic                     win_found;
  logic [P_IDX_WIDTH-1:0]   win_idx;
  logic [P_IDX_WIDTH-1:0]   cand;
  logic                     timeout_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int P_CNT_W = $clog2(P_MAX_HOLD);
  logic [P_CNT_W-1:0] hold_cnt;

  // Counter sits at zero outside HOLD, so the first HOLD cycle always reads 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_cnt <= '0;
    end else if (state == ST_HOLD) begin
      hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end

  assign timeout_hit = (state == ST_HOLD) && (hold_cnt == P_CNT_W'(P_MAX_HOLD - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Walk from the pointer upward, wrapping at N rather than at 2^P_IDX_WIDTH.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = ptr;
    for (int k = 0; k < P_CHANNEL_NUM; k++) begin
      if (!win_found && bus.i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grant_n = bus.o_grant;
    idx_n   = bus.o_grant_idx;
    busy_n  = bus.o_busy;
    gv_n    = 1'b0;
    to_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.i_req_valid && win_found) begin
          state_n = ST_HOLD;
          grant_n = {{(P_CHANNEL_NUM-1){1'b0}}, 1'b1} << win_idx;
          idx_n   = win_idx;
          busy_n  = 1'b1;
          gv_n    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.i_release || timeout_hit) begin
          state_n = ST_GAP;
          grant_n = '0;
          busy_n  = 1'b0;
          ptr_n   = (bus.o_grant_idx == LAST_IDX) ? '0 : bus.o_grant_idx + 1'b1;
          to_n    = !bus.i_release;
        end
      end
      ST_GAP:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state             <= ST_IDLE;
      ptr               <= '0;
      bus.o_grant       <= '0;
      bus.o_grant_idx   <= '0;
      bus.o_grant_valid <= 1'b0;
      bus.o_busy        <= 1'b0;
      bus.o_timeout     <= 1'b0;
    end else begin
      state             <= state_n;
      ptr               <= ptr_n;
      bus.o_grant       <= grant_n;
      bus.o_grant_idx   <= idx_n;
      bus.o_grant_valid <= gv_n;
      bus.o_busy        <= busy_n;
      bus.o_timeout     <= to_n;
    end
  end
endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb/tb_rr_lock_arbiter.sv - directed bench with a cycle model for rr_lock_arbiter
module tb_rr_lock_arbiter;
  localparam int N    = 8;
  localparam int W    = 3;
  localparam int MAXH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_lock_arbiter_if #(.P_CHANNEL_NUM(N), .P_IDX_WIDTH(W)) bus ();

  rr_lock_arbiter #(.P_CHANNEL_NUM(N), .P_IDX_WIDTH(W), .P_MAX_HOLD(MAXH)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: who owns the grant, rotating priority, one dead cycle after release.
  int       m_owner = -1;
  int       m_ptr   = 0;
  int       m_age   = 0;
  int       m_w;
  bit       m_gap   = 1'b0;
  bit       m_new   = 1'b0;
  bit       m_to    = 1'b0;
  logic [N-1:0] m_grant;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (p + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_age = 0; m_gap = 1'b0; m_new = 1'b0; m_to = 1'b0;
    end else begin
      m_new = 1'b0;
      m_to  = 1'b0;
      if (m_owner >= 0) begin
        if (bus.i_release || (TO_EN && m_age == MAXH)) begin
          m_to    = !bus.i_release;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_gap   = 1'b1;
        end else begin
          m_age++;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (bus.i_req_valid) begin
        m_w = pick(bus.i_req, m_ptr);
        if (m_w >= 0) begin
          m_owner = m_w; m_age = 1; m_new = 1'b1;
        end
      end
    end
    #1;
    m_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check("model_busy", bus.o_busy, m_owner >= 0);
    check("model_grant", bus.o_grant, m_grant);
    check("model_gvalid", bus.o_grant_valid, m_new);
    check("model_timeout", bus.o_timeout, m_to);
    if (m_owner >= 0) check("model_idx", bus.o_grant_idx, m_owner);
  end

  task automatic cyc(input logic [N-1:0] r, input logic v, input logic rl);
    bus.i_req       = r;
    bus.i_req_valid = v;
    bus.i_release   = rl;
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.i_req = '0; bus.i_req_valid = 1'b0; bus.i_release = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", bus.o_grant, 0);
    check("rst_idx", bus.o_grant_idx, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_gvalid", bus.o_grant_valid, 0);
    check("rst_timeout", bus.o_timeout, 0);
    rst_n = 1'b1;

    repeat (3) begin
      cyc(8'h00, 1'b1, 1'b0);
      check("empty_grant", bus.o_grant, 0);
      check("empty_gvalid", bus.o_grant_valid, 0);
    end

    cyc(8'hA4, 1'b1, 1'b0);
    check("first_grant", bus.o_grant, 8'h04);
    check("first_idx", bus.o_grant_idx, 2);
    check("first_gvalid", bus.o_grant_valid, 1);
    check("first_busy", bus.o_busy, 1);
    cyc(8'hA4, 1'b0, 1'b0);
    check("gvalid_pulse", bus.o_grant_valid, 0);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b1);
    check("release_grant", bus.o_grant, 0);
    check("release_busy", bus.o_busy, 0);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'hA4, 1'b1, 1'b0);
    check("second_grant", bus.o_grant, 8'h20);
    check("second_idx", bus.o_grant_idx, 5);
    cyc(8'h00, 1'b0, 1'b1);

    reset_pulse();
    for (int i = 0; i < 9; i++) begin
      cyc(8'hFF, 1'b1, 1'b0);
      check("fair_idx", bus.o_grant_idx, i % 8);
      check("fair_gvalid", bus.o_grant_valid, 1);
      if (i == 8) break;
      cyc(8'hFF, 1'b1, 1'b0);
      cyc(8'hFF, 1'b1, 1'b1);
      cyc(8'hFF, 1'b1, 1'b0);
      check("fair_gap_grant", bus.o_grant, 0);
    end
    cyc(8'hFF, 1'b1, 1'b1);
    cyc(8'h00, 1'b0, 1'b0);

    cyc(8'h40, 1'b1, 1'b0);
    check("wrap_pre_idx", bus.o_grant_idx, 6);
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h81, 1'b1, 1'b0);
    check("wrap_idx7", bus.o_grant_idx, 7);
    check("wrap_grant7", bus.o_grant, 8'h80);
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h81, 1'b1, 1'b0);
    check("wrap_idx0", bus.o_grant_idx, 0);
    check("wrap_grant0", bus.o_grant, 8'h01);

    cyc(8'h0E, 1'b1, 1'b0);
    check("hold_ignore_a", bus.o_grant, 8'h01);
    cyc(8'hF0, 1'b1, 1'b0);
    check("hold_ignore_b", bus.o_grant, 8'h01);
    cyc(8'h02, 1'b1, 1'b1);
    check("rel_and_req_busy", bus.o_busy, 0);
    check("rel_and_req_grant", bus.o_grant, 0);
    cyc(8'h02, 1'b1, 1'b0);
    check("gap_ignore", bus.o_grant, 0);
    cyc(8'h00, 1'b0, 1'b0);
    check("gap_not_queued", bus.o_grant, 0);
    cyc(8'h00, 1'b0, 1'b1);
    check("idle_release", bus.o_busy, 0);
    cyc(8'h06, 1'b1, 1'b0);
    check("ptr_after_idx0", bus.o_grant_idx, 1);

    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", bus.o_grant, 0);
    check("async_rst_busy", bus.o_busy, 0);
    check("async_rst_idx", bus.o_grant_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(8'h81, 1'b1, 1'b0);
    check("post_rst_idx", bus.o_grant_idx, 0);
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
    cyc(8'h10, 1'b1, 1'b0);
    check("to_grant_idx", bus.o_grant_idx, 4);
    repeat (3) begin
      cyc(8'h00, 1'b0, 1'b0);
      check("to_still_busy", bus.o_busy, 1);
      check("to_no_pulse", bus.o_timeout, 0);
    end
    cyc(8'h00, 1'b0, 1'b0);
    check("to_busy_fall", bus.o_busy, 0);
    check("to_pulse", bus.o_timeout, 1);
    cyc(8'h00, 1'b0, 1'b0);
    check("to_one_pulse", bus.o_timeout, 0);
    cyc(8'h10, 1'b1, 1'b0);
    repeat (3) cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b1);
    check("to_rel_busy", bus.o_busy, 0);
    check("to_rel_no_pulse", bus.o_timeout, 0);
`else
    cyc(8'h10, 1'b1, 1'b0);
    repeat (6) cyc(8'h00, 1'b0, 1'b0);
    check("nto_hold_busy", bus.o_busy, 1);
    check("nto_timeout", bus.o_timeout, 0);
    cyc(8'h00, 1'b0, 1'b1);
    check("nto_release", bus.o_busy, 0);
`endif
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
